chip_top_soc: RTL and testbench
===============================

# chip_top_soc

Single-clock peripheral hub for the lowRISC chip top level. It exposes a simple register bus to the core/host side and provides:
- an LED/DIP/push-button GPIO block
- an 8N1 UART with programmable baud divider and RTS/CTS flow control
- a tohost exit register that signals pass/fail to the simulation environment
- a free-running cycle counter

## Interface
Parameters:
- BAUD_RESET, 16'd52, reset value of the UART baud divider (clocks per bit).
- DIP_W, 16, width of the DIP switch input.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock; all logic on its rising edge.
- rst_top  in  1  synchronous active-low reset.
- bus_addr  in  8  byte address; bits [1:0] ignored.
- bus_wdata  in  32  write data.
- bus_we  in  1  write request, single-cycle pulse.
- bus_re  in  1  read request, single-cycle pulse.
- bus_rdata  out  32  read data, valid while bus_ack=1.
- bus_ack  out  1  access complete.
- rxd  in  1  UART serial input, idle high.
- txd  out  1  UART serial output, idle high.
- cts  in  1  clear-to-send; 1 = transmission permitted.
- rts  out  1  1 = receive buffer full, peer must hold off.
- i_dip  in  DIP_W  DIP switches.
- GPIO_SW_C, GPIO_SW_W, GPIO_SW_E, GPIO_SW_N, GPIO_SW_S  in  1 each  push buttons.
- o_led  out  8  LEDs.
- irq  out  1  interrupt; equals rx_valid.
- exit_valid  out  1  sticky; program has written tohost.
- exit_code  out  31  exit status; 0 = pass.

## Operation
Register map (byte offsets):
- 0x00 LED: RW; bits [7:0] drive o_led.
- 0x04 INPUT: RO; {11'b0, SW_S, SW_N, SW_E, SW_W, SW_C, i_dip}.
- 0x08 UART_TX: WO.
  - Write of wdata[7:0] starts a frame if tx idle and cts=1.
  - Otherwise the write is dropped; no queueing.
- 0x0C UART_RX: RO; {rx_valid, 23'b0, rx_byte}. A read clears rx_valid.
- 0x10 UART_STATUS:
  - bit0 tx_busy, bit1 rx_valid, bit2 overrun, bit3 frame_err, bit4 cts.
  - Writing 1 to bit2 or bit3 clears that bit.
- 0x14 UART_BAUD: RW 16 bits; clocks per bit; writes below 4 are stored as 4.
- 0x18 TOHOST: write with wdata[0]=1 sets exit_valid=1 and exit_code=wdata[31:1]. Writes with wdata[0]=0 are ignored.
- 0x1C CYCLE: RO; low 32 bits of a counter incremented every clock from reset; wraps at 2^32.
- Unmapped addresses: read 0; writes ignored; still acked.

UART frame format: 8N1, LSB first.

UART TX:
- Frame = start(0), 8 data bits, stop(1); each bit held BAUD clocks.
- tx_busy=1 from the cycle after the accepted write until the stop bit ends.

UART RX:
- rxd is passed through a 2-flop synchronizer.
- A falling edge while idle starts reception. The line is sampled at BAUD/2 for the start bit, then every BAUD.
- Start sample high: false start; return to idle, no flags.
- Stop sample 0: set frame_err; discard the byte.
- Byte received while rx_valid=1: set overrun; the new byte overwrites rx_byte.
- rts = rx_valid.

Exit register: exit_valid/exit_code stay sticky until reset. Later TOHOST writes are ignored once exit_valid=1.

## Timing
- Bus access:
  - bus_ack pulses for exactly 1 cycle, the cycle after bus_we or bus_re.
  - bus_rdata holds the read value during ack and is 0 otherwise.
- bus_we and bus_re together: the write is performed, bus_rdata=0, one ack.
- Register writes take effect the cycle after the request. An LED write at cycle N appears on o_led at N+1.
- txd start bit begins the cycle after the UART_TX write is registered.
- rx_valid rises 1 cycle after the stop-bit sample. If a byte completes in the same cycle as an RX read, rx_valid stays 1 with the new byte.
- Reset values, held while rst_top=0:
  - o_led=0, txd=1, rts=0, irq=0, bus_ack=0, bus_rdata=0
  - exit_valid=0, exit_code=0, baud=BAUD_RESET, cycle counter=0
  - all UART state idle, all status flags 0
- Reset mid-frame: txd returns to 1 on the next clock; any partially received byte is lost.
- Inputs i_dip and the GPIO_SW_* buttons are sampled combinationally into the read mux.

## Test plan
- Reset: hold rst_top=0 for 10 cycles, release. Required: txd=1, o_led=0, exit_valid=0, UART_BAUD reads 52, CYCLE increments by 1 per cycle.
- GPIO: write 0xA5 to 0x00 → o_led=0xA5 next cycle. With i_dip=16'h000E and all buttons =1, reading 0x04 → 0x001F000E.
- UART loopback (txd tied to rxd, cts=1, baud 52): write 0x55 to 0x08 → frame on txd of 10×52 cycles. Then rx_valid=1, irq=1, rts=1; reading 0x0C → 0x80000055; rx_valid then clears.
- UART errors:
  - Inject a frame with stop bit 0 → frame_err=1, rx_valid=0.
  - Send two bytes without reading → overrun=1, second byte returned.
  - Write 0xC to 0x10 → both flags clear.
- TX busy/CTS: a second UART_TX write while tx_busy is dropped; a write with cts=0 does not start a frame.
- Exit: write 0x1 to 0x18 → exit_valid=1, exit_code=0. After reset, write 0x7 → exit_code=3; a later write of 0x1 leaves exit_code=3.

Source files
------------

// File: rtl/chip_top_soc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : chip_top_soc
// Description : Register-bus peripheral hub: GPIO, 8N1 UART with RTS/CTS,
//               tohost exit register and free-running cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module chip_top_soc #(
    parameter logic [15:0] BAUD_RESET = 16'd52,
    parameter int          DIP_W      = 16
) (
    input  logic             clk,
    input  logic             rst_top,
    input  logic [7:0]       bus_addr,
    input  logic [31:0]      bus_wdata,
    input  logic             bus_we,
    input  logic             bus_re,
    output logic [31:0]      bus_rdata,
    output logic             bus_ack,
    input  logic             rxd,
    output logic             txd,
    input  logic             cts,
    output logic             rts,
    input  logic [DIP_W-1:0] i_dip,
    input  logic             GPIO_SW_C,
    input  logic             GPIO_SW_W,
    input  logic             GPIO_SW_E,
    input  logic             GPIO_SW_N,
    input  logic             GPIO_SW_S,
    output logic [7:0]       o_led,
    output logic             irq,
    output logic             exit_valid,
    output logic [30:0]      exit_code
);

    localparam logic [5:0] C_IDX_LED    = 6'd0;
    localparam logic [5:0] C_IDX_INPUT  = 6'd1;
    localparam logic [5:0] C_IDX_TX     = 6'd2;
    localparam logic [5:0] C_IDX_RX     = 6'd3;
    localparam logic [5:0] C_IDX_STATUS = 6'd4;
    localparam logic [5:0] C_IDX_BAUD   = 6'd5;
    localparam logic [5:0] C_IDX_TOHOST = 6'd6;
    localparam logic [5:0] C_IDX_CYCLE  = 6'd7;

    localparam logic [1:0] C_RX_IDLE  = 2'd0;
    localparam logic [1:0] C_RX_START = 2'd1;
    localparam logic [1:0] C_RX_DATA  = 2'd2;
    localparam logic [1:0] C_RX_STOP  = 2'd3;

    logic [7:0]  r_led;
    logic [15:0] r_baud;
    logic [31:0] r_cycle;
    logic        r_exit_valid;
    logic [30:0] r_exit_code;
    logic        r_ack;
    logic [31:0] r_rdata;

    logic        r_tx_busy;
    logic        r_txd;
    logic [8:0]  r_tx_shift;
    logic [15:0] r_tx_cnt;
    logic [3:0]  r_tx_bits;

    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    logic [1:0]  r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bits;
    logic [7:0]  r_rx_shift;
    logic        r_rx_done;
    logic [7:0]  r_rx_byte;
    logic        r_rx_valid;
    logic        r_overrun;
    logic        r_frame_err;

    logic [5:0]  w_idx;
    logic        w_rd;
    logic        w_tx_start;
    logic        w_rx_read;
    logic        w_stat_wr;
    logic        w_rx_fall;
    logic [31:0] w_input;
    logic [31:0] w_rmux;
    logic        w_unused;

    assign w_idx      = bus_addr[7:2];
    // A simultaneous write wins: the access is treated purely as a write.
    assign w_rd       = bus_re & ~bus_we;
    assign w_tx_start = bus_we && (w_idx == C_IDX_TX) && !r_tx_busy && cts;
    assign w_rx_read  = w_rd && (w_idx == C_IDX_RX);
    assign w_stat_wr  = bus_we && (w_idx == C_IDX_STATUS);
    assign w_rx_fall  = r_rx_prev & ~r_rx_s2;
    assign w_input    = {{(27-DIP_W){1'b0}}, GPIO_SW_S, GPIO_SW_N, GPIO_SW_E,
                         GPIO_SW_W, GPIO_SW_C, i_dip};
    assign w_unused   = ^bus_addr[1:0];

    always_comb begin
        w_rmux = 32'd0;
        case (w_idx)
            C_IDX_LED:    w_rmux = {24'd0, r_led};
            C_IDX_INPUT:  w_rmux = w_input;
            C_IDX_RX:     w_rmux = {r_rx_valid, 23'd0, r_rx_byte};
            C_IDX_STATUS: w_rmux = {27'd0, cts, r_frame_err, r_overrun, r_rx_valid, r_tx_busy};
            C_IDX_BAUD:   w_rmux = {16'd0, r_baud};
            C_IDX_TOHOST: w_rmux = {r_exit_code, r_exit_valid};
            C_IDX_CYCLE:  w_rmux = r_cycle;
            default:      w_rmux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_top) begin
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack   <= bus_we | bus_re;
            r_rdata <= w_rd ? w_rmux : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_top) begin
            r_led        <= 8'd0;
            r_baud       <= BAUD_RESET;
            r_cycle      <= 32'd0;
            r_exit_valid <= 1'b0;
            r_exit_code  <= 31'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (bus_we && (w_idx == C_IDX_LED))
                r_led <= bus_wdata[7:0];
            if (bus_we && (w_idx == C_IDX_BAUD))
                r_baud <= (bus_wdata[15:0] < 16'd4) ? 16'd4 : bus_wdata[15:0];
            if (bus_we && (w_idx == C_IDX_TOHOST) && bus_wdata[0] && !r_exit_valid) begin
                r_exit_valid <= 1'b1;
                r_exit_code  <= bus_wdata[31:1];
            end
        end
    end

    // Transmitter: shift register holds the data bits followed by the stop bit.
    always_ff @(posedge clk) begin
        if (!rst_top) begin
            r_tx_busy  <= 1'b0;
            r_txd      <= 1'b1;
            r_tx_shift <= 9'd0;
            r_tx_cnt   <= 16'd0;
            r_tx_bits  <= 4'd0;
        end else if (w_tx_start) begin
            r_tx_busy  <= 1'b1;
            r_txd      <= 1'b0;
            r_tx_shift <= {1'b1, bus_wdata[7:0]};
            r_tx_cnt   <= 16'd0;
            r_tx_bits  <= 4'd0;
        end else if (r_tx_busy) begin
            if (r_tx_cnt >= r_baud - 16'd1) begin
                r_tx_cnt <= 16'd0;
                if (r_tx_bits == 4'd9) begin
                    r_tx_busy <= 1'b0;
                    r_txd     <= 1'b1;
                end else begin
                    r_txd      <= r_tx_shift[0];
                    r_tx_shift <= {1'b0, r_tx_shift[8:1]};
                    r_tx_bits  <= r_tx_bits + 4'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
        end
    end

    // Receiver: status clears are applied first so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (!rst_top) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_rx_state  <= C_RX_IDLE;
            r_rx_cnt    <= 16'd0;
            r_rx_bits   <= 3'd0;
            r_rx_shift  <= 8'd0;
            r_rx_done   <= 1'b0;
            r_rx_byte   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_s1   <= rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_rx_done <= 1'b0;
            if (w_stat_wr && bus_wdata[2]) r_overrun   <= 1'b0;
            if (w_stat_wr && bus_wdata[3]) r_frame_err <= 1'b0;
            case (r_rx_state)
                C_RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= C_RX_START;
                        r_rx_cnt   <= 16'd0;
                    end
                end
                C_RX_START: begin
                    if (r_rx_cnt >= {1'b0, r_baud[15:1]}) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_bits  <= 3'd0;
                        r_rx_state <= r_rx_s2 ? C_RX_IDLE : C_RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                C_RX_DATA: begin
                    if (r_rx_cnt >= r_baud - 16'd1) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_bits  <= r_rx_bits + 3'd1;
                        if (r_rx_bits == 3'd7) r_rx_state <= C_RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                C_RX_STOP: begin
                    if (r_rx_cnt >= r_baud - 16'd1) begin
                        r_rx_cnt   <= 16'd0;
                        r_rx_state <= C_RX_IDLE;
                        if (r_rx_s2) r_rx_done   <= 1'b1;
                        else         r_frame_err <= 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                default: r_rx_state <= C_RX_IDLE;
            endcase
            if (r_rx_done) begin
                r_rx_byte  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !w_rx_read) r_overrun <= 1'b1;
            end else if (w_rx_read) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign bus_rdata  = r_rdata;
    assign bus_ack    = r_ack;
    assign txd        = r_txd;
    assign rts        = r_rx_valid;
    assign irq        = r_rx_valid;
    assign o_led      = r_led;
    assign exit_valid = r_exit_valid;
    assign exit_code  = r_exit_code;

endmodule
`default_nettype wire

// File: tb/tb_chip_top_soc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_chip_top_soc
// Description : Directed/randomised self-checking bench for chip_top_soc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chip_top_soc;

    logic        clk = 1'b0;
    logic        rst_top;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we, bus_re;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        rxd, txd, cts, rts;
    logic [15:0] i_dip;
    logic        sw_c, sw_w, sw_e, sw_n, sw_s;
    logic [7:0]  o_led;
    logic        irq, exit_valid;
    logic [30:0] exit_code;
    logic        loopback, rxd_drv;

    int checks   = 0;
    int failures = 0;
    int baud     = 52;
    logic rd_ack;

    assign rxd = loopback ? txd : rxd_drv;

    always #5 clk = ~clk;

    chip_top_soc #(.BAUD_RESET(16'd52), .DIP_W(16)) dut (
        .clk(clk), .rst_top(rst_top),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .rxd(rxd), .txd(txd), .cts(cts), .rts(rts),
        .i_dip(i_dip),
        .GPIO_SW_C(sw_c), .GPIO_SW_W(sw_w), .GPIO_SW_E(sw_e),
        .GPIO_SW_N(sw_n), .GPIO_SW_S(sw_s),
        .o_led(o_led), .irq(irq), .exit_valid(exit_valid), .exit_code(exit_code)
    );

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        @(negedge clk);
        bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_addr = a; bus_re = 1'b1;
        @(negedge clk);
        bus_re = 1'b0;
        d = bus_rdata;
        rd_ack = bus_ack;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected UART_STATUS from abstract flag values.
    function automatic logic [31:0] status_of(input int c, input int fe, input int ov,
                                              input int rv, input int busy);
        return 32'(c * 16 + fe * 8 + ov * 4 + rv * 2 + busy);
    endfunction

    // Drive one 8N1 frame onto rxd at the bench baud, then one idle bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd_drv = bits[k];
            wait_cycles(baud);
        end
        rxd_drv = 1'b1;
        wait_cycles(baud);
    endtask

    // Transmit through loopback, check the line bit-by-bit and the received byte.
    task automatic loop_byte(input logic [7:0] b);
        logic [9:0]  seen;
        logic [31:0] rd;
        bus_write(8'h08, {24'd0, b});
        wait_cycles(baud / 2);
        for (int k = 0; k < 10; k++) begin
            seen[k] = txd;
            if (k < 9) wait_cycles(baud);
        end
        check("tx_frame_bits", {22'd0, seen}, {22'd0, 1'b1, b, 1'b0});
        wait_cycles(baud);
        check("rx_irq", {31'd0, irq}, 32'd1);
        check("rx_rts", {31'd0, rts}, 32'd1);
        bus_read(8'h10, rd);
        check("rx_status", rd, status_of(1, 0, 0, 1, 0));
        bus_read(8'h0C, rd);
        check("rx_data", rd, 32'h8000_0000 | {24'd0, b});
        @(negedge clk);
        check("rx_irq_clear", {31'd0, irq}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd, rd2, expv;
        logic [7:0]  b, b2;
        logic [15:0] v;
        logic [30:0] code;
        int n;
        logic saw_low;

        rst_top = 1'b0; bus_addr = 8'd0; bus_wdata = 32'd0; bus_we = 1'b0; bus_re = 1'b0;
        rxd_drv = 1'b1; loopback = 1'b0; cts = 1'b1; i_dip = 16'd0;
        sw_c = 1'b0; sw_w = 1'b0; sw_e = 1'b0; sw_n = 1'b0; sw_s = 1'b0;
        rd_ack = 1'b0;

        // Reset values
        wait_cycles(10);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_led", {24'd0, o_led}, 32'd0);
        check("rst_exit", {exit_code, exit_valid}, 32'd0);
        check("rst_rts_irq", {30'd0, rts, irq}, 32'd0);
        check("rst_bus", {bus_rdata[30:0], bus_ack}, 32'd0);
        rst_top = 1'b1;

        bus_read(8'h14, rd);
        check("baud_reset", rd, 32'd52);
        check("read_ack", {31'd0, rd_ack}, 32'd1);
        @(negedge clk);
        check("ack_one_cycle", {31'd0, bus_ack}, 32'd0);
        check("rdata_idle_zero", bus_rdata, 32'd0);

        bus_read(8'h1C, rd);
        bus_read(8'h1C, rd2);
        check("cycle_step", rd2 - rd, 32'd2);
        n = $urandom_range(0, 40);
        bus_read(8'h1C, rd);
        wait_cycles(n);
        bus_read(8'h1C, rd2);
        check("cycle_gap", rd2 - rd, 32'(n + 2));

        // GPIO
        bus_write(8'h00, 32'h0000_00A5);
        check("led_a5", {24'd0, o_led}, 32'hA5);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            bus_write(8'h00, {$urandom, b} >> 0 & 32'hFFFF_FF00 | {24'd0, b});
            check("led_rand", {24'd0, o_led}, {24'd0, b});
            bus_read(8'h00, rd);
            check("led_readback", rd, {24'd0, b});
        end
        i_dip = 16'h000E; {sw_s, sw_n, sw_e, sw_w, sw_c} = 5'b11111;
        bus_read(8'h04, rd);
        check("input_plan", rd, 32'h001F_000E);
        for (int i = 0; i < 3; i++) begin
            i_dip = 16'($urandom);
            {sw_s, sw_n, sw_e, sw_w, sw_c} = 5'($urandom);
            expv = 32'(sw_s) * 32'h10_0000 + 32'(sw_n) * 32'h8_0000 + 32'(sw_e) * 32'h4_0000
                 + 32'(sw_w) * 32'h2_0000 + 32'(sw_c) * 32'h1_0000 + 32'(i_dip);
            bus_read(8'h04, rd);
            check("input_rand", rd, expv);
        end

        // Simultaneous write and read: write wins, data reads 0
        b = 8'($urandom);
        @(negedge clk);
        bus_addr = 8'h00; bus_wdata = {24'd0, b}; bus_we = 1'b1; bus_re = 1'b1;
        @(negedge clk);
        bus_we = 1'b0; bus_re = 1'b0;
        check("we_re_ack", {31'd0, bus_ack}, 32'd1);
        check("we_re_rdata", bus_rdata, 32'd0);
        check("we_re_led", {24'd0, o_led}, {24'd0, b});

        bus_read(8'hA0, rd);
        check("unmapped_read", rd, 32'd0);
        check("unmapped_ack", {31'd0, rd_ack}, 32'd1);

        // Baud clamp
        bus_write(8'h14, 32'($urandom_range(0, 3)));
        bus_read(8'h14, rd);
        check("baud_clamp", rd, 32'd4);
        v = 16'($urandom_range(4, 1000));
        bus_write(8'h14, {16'hDEAD, v});
        bus_read(8'h14, rd);
        check("baud_store", rd, {16'd0, v});

        // UART loopback
        loopback = 1'b1;
        bus_write(8'h14, 32'd52); baud = 52;
        loop_byte(8'h55);
        loop_byte(8'($urandom));
        bus_write(8'h14, 32'd16); baud = 16;
        loop_byte(8'($urandom));
        loop_byte(8'($urandom));
        bus_write(8'h14, 32'd52); baud = 52;

        // Second write while busy is dropped
        b = 8'($urandom); b2 = ~b;
        bus_write(8'h08, {24'd0, b});
        bus_read(8'h10, rd);
        check("tx_busy", rd, status_of(1, 0, 0, 0, 1));
        bus_write(8'h08, {24'd0, b2});
        wait_cycles(12 * baud);
        bus_read(8'h0C, rd);
        check("drop_first_kept", rd, 32'h8000_0000 | {24'd0, b});
        wait_cycles(12 * baud);
        check("drop_no_second", {31'd0, irq}, 32'd0);
        bus_read(8'h10, rd);
        check("drop_idle_status", rd, status_of(1, 0, 0, 0, 0));

        // CTS low blocks transmission
        cts = 1'b0;
        bus_write(8'h08, 32'h0000_0000);
        bus_read(8'h10, rd);
        check("cts_block_status", rd, status_of(0, 0, 0, 0, 0));
        saw_low = 1'b0;
        for (int i = 0; i < 3 * baud; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) saw_low = 1'b1;
        end
        check("cts_block_line", {31'd0, saw_low}, 32'd0);
        cts = 1'b1;

        // Injected errors
        loopback = 1'b0;
        send_frame(8'($urandom), 1'b0);
        bus_read(8'h10, rd);
        check("frame_err", rd, status_of(1, 1, 0, 0, 0));
        b = 8'($urandom); b2 = 8'($urandom);
        send_frame(b, 1'b1);
        send_frame(b2, 1'b1);
        bus_read(8'h10, rd);
        check("overrun", rd, status_of(1, 1, 1, 1, 0));
        bus_read(8'h0C, rd);
        check("overrun_data", rd, 32'h8000_0000 | {24'd0, b2});
        bus_write(8'h10, 32'h0000_000C);
        bus_read(8'h10, rd);
        check("err_clear", rd, status_of(1, 0, 0, 0, 0));

        // Reset mid-frame
        loopback = 1'b1;
        bus_write(8'h08, 32'h0000_0000);
        wait_cycles(100);
        rst_top = 1'b0;
        @(negedge clk);
        check("rst_mid_txd", {31'd0, txd}, 32'd1);
        wait_cycles(3);
        rst_top = 1'b1; baud = 52;
        wait_cycles(20);
        bus_read(8'h10, rd);
        check("rst_mid_status", rd, status_of(1, 0, 0, 0, 0));

        // Exit register
        bus_write(8'h18, 32'h0000_0001);
        check("exit_pass", {exit_code, exit_valid}, {31'd0, 1'b1});
        rst_top = 1'b0; wait_cycles(10); rst_top = 1'b1;
        check("exit_rst", {exit_code, exit_valid}, 32'd0);
        bus_write(8'h18, 32'h0000_0007);
        check("exit_code3", {exit_code, exit_valid}, {31'd3, 1'b1});
        bus_write(8'h18, 32'h0000_0001);
        check("exit_sticky", {exit_code, exit_valid}, {31'd3, 1'b1});
        rst_top = 1'b0; wait_cycles(10); rst_top = 1'b1;
        code = 31'($urandom);
        bus_write(8'h18, {code, 1'b0});
        check("exit_ignore_bit0", {31'd0, exit_valid}, 32'd0);
        bus_write(8'h18, {code, 1'b1});
        check("exit_rand", {exit_code, exit_valid}, {code, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
